// File: rtl/leds_jogador_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leds_jogador_decoder_pkg
//  Description : Game-wide constants shared by the player LED decoder:
//                player codes, decoder state encoding and the helpers that
//                turn a player code into a one-hot LED pattern and check
//                whether a code may be loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
package leds_jogador_decoder_pkg;

    // Player codes as produced by the player-button encoder
    localparam logic [2:0] JOGADOR_0 = 3'd0;
    localparam logic [2:0] JOGADOR_1 = 3'd1;
    localparam logic [2:0] JOGADOR_2 = 3'd2;
    localparam logic [2:0] JOGADOR_3 = 3'd3;
    localparam logic [2:0] JOGADOR_4 = 3'd4;
    localparam logic [2:0] PULAR     = 3'd5;
    localparam logic [2:0] NENHUM    = 3'd7;

    // Decoder state encoding
    typedef logic [1:0] estado_t;
    localparam estado_t OCIOSO = 2'd0;
    localparam estado_t FIXO   = 2'd1;
    localparam estado_t PISCA  = 2'd2;

    // One-hot LED pattern for a code; codes 6/7 light nothing
    function automatic logic [5:0] onehot_codigo(input logic [2:0] codigo);
        logic [5:0] r;
        case (codigo)
            JOGADOR_0: r = 6'b000001;
            JOGADOR_1: r = 6'b000010;
            JOGADOR_2: r = 6'b000100;
            JOGADOR_3: r = 6'b001000;
            JOGADOR_4: r = 6'b010000;
            PULAR:     r = 6'b100000;
            default:   r = 6'b000000;
        endcase
        return r;
    endfunction

    // A player code is loadable only if that player is alive; Pular always is
    function automatic logic codigo_valido(input logic [2:0] codigo,
                                           input logic [4:0] vivos);
        logic r;
        case (codigo)
            JOGADOR_0: r = vivos[0];
            JOGADOR_1: r = vivos[1];
            JOGADOR_2: r = vivos[2];
            JOGADOR_3: r = vivos[3];
            JOGADOR_4: r = vivos[4];
            PULAR:     r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leds_jogador_decoder_pisca_temporizador.sv
`default_nettype none
// ============================================================================
//  Module      : pisca_temporizador
//  Description : Blink timer. Counts half-periods of HALF_PERIOD cycles,
//                toggles the blink phase at each half-period boundary and
//                flags the edge on which the N_TOGGLES-th boundary occurs.
//  Ports       : clock, reset  - clock / async active-high reset
//                start         - restart sequence (phase on, counters 0)
//                stop          - hold counters cleared, phase off
//                fase          - phase that applies after the next edge
//                done          - this edge completes the sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module pisca_temporizador #(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int N_TOGGLES   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic fase,
    output logic done
);

    localparam int CNT_W = $clog2(HALF_PERIOD);
    localparam int TOG_W = $clog2(N_TOGGLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [TOG_W-1:0] C_TOG_ULT  = TOG_W'(N_TOGGLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TOG_W-1:0] toggles_q, toggles_d;
    logic             fase_q, fase_d;
    logic             w_virada;

    always_comb begin
        cnt_d     = cnt_q;
        toggles_d = toggles_q;
        fase_d    = fase_q;
        done      = 1'b0;
        w_virada  = (cnt_q == C_CNT_MAX);
        if (start) begin
            cnt_d     = '0;
            toggles_d = '0;
            fase_d    = 1'b1;
        end else if (stop) begin
            cnt_d     = '0;
            toggles_d = '0;
            fase_d    = 1'b0;
        end else if (w_virada) begin
            cnt_d     = '0;
            fase_d    = ~fase_q;
            toggles_d = toggles_q + TOG_W'(1);
            // Last boundary: the parent leaves PISCA, which then holds us in stop
            done      = (toggles_q == C_TOG_ULT);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The parent registers its LEDs from the next phase, so expose fase_d
    assign fase = fase_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            toggles_q <= '0;
            fase_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            toggles_q <= toggles_d;
            fase_q    <= fase_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/leds_jogador_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : leds_jogador_decoder
//  Description : Drives the six one-hot player/skip LEDs from a 3-bit player
//                code, either steadily (FIXO) or as a timed blink sequence
//                (PISCA). Rejects invalid / dead-player codes with a one-cycle
//                invalido pulse; signals natural end of a blink with fim.
//  Ports       : clock, reset  - clock / async active-high reset
//                carrega       - load strobe (samples jogador/vivos/modo)
//                jogador[2:0]  - player code (0-4 player, 5 Pular, 6/7 none)
//                vivos[4:0]    - alive mask
//                modo_pisca    - 0 steady, 1 blink sequence
//                limpa         - clear display, return to idle
//                leds[5:0]     - one-hot LED drive (registered)
//                ocupado       - high in FIXO or PISCA (registered)
//                invalido      - one-cycle pulse on rejected load
//                fim           - one-cycle pulse when a blink completes
//  Revision    : 1.0 - initial release
// ============================================================================
module leds_jogador_decoder
    import leds_jogador_decoder_pkg::*;
#(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int N_TOGGLES   = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic [2:0] jogador,
    input  logic [4:0] vivos,
    input  logic       modo_pisca,
    input  logic       limpa,
    output logic [5:0] leds,
    output logic       ocupado,
    output logic       invalido,
    output logic       fim
);

    estado_t    estado_q, estado_d;
    logic [2:0] codigo_q, codigo_d;
    logic [5:0] leds_q, leds_d;
    logic       ocupado_q, ocupado_d;
    logic       invalido_q, invalido_d;
    logic       fim_q, fim_d;

    logic       w_iniciar;
    logic       w_parar;
    logic       w_fase;
    logic       w_fim_seq;

    // Counters stay cleared outside PISCA; a valid load always restarts them
    assign w_parar = (estado_q != PISCA);

    pisca_temporizador #(
        .HALF_PERIOD (HALF_PERIOD),
        .N_TOGGLES   (N_TOGGLES)
    ) u_pisca_temporizador (
        .clock (clock),
        .reset (reset),
        .start (w_iniciar),
        .stop  (w_parar),
        .fase  (w_fase),
        .done  (w_fim_seq)
    );

    always_comb begin
        estado_d   = estado_q;
        codigo_d   = codigo_q;
        invalido_d = 1'b0;
        fim_d      = 1'b0;
        w_iniciar  = 1'b0;

        // limpa outranks carrega; a load outranks a completing sequence,
        // so an aborted blink never raises fim
        if (limpa) begin
            estado_d = OCIOSO;
            codigo_d = NENHUM;
        end else if (carrega) begin
            if (codigo_valido(jogador, vivos)) begin
                codigo_d  = jogador;
                estado_d  = modo_pisca ? PISCA : FIXO;
                w_iniciar = 1'b1;
            end else begin
                estado_d   = OCIOSO;
                codigo_d   = NENHUM;
                invalido_d = 1'b1;
            end
        end else if ((estado_q == PISCA) && w_fim_seq) begin
            estado_d = OCIOSO;
            fim_d    = 1'b1;
        end

        case (estado_d)
            FIXO:    leds_d = onehot_codigo(codigo_d);
            PISCA:   leds_d = w_fase ? onehot_codigo(codigo_d) : 6'b000000;
            default: leds_d = 6'b000000;
        endcase

        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            codigo_q   <= NENHUM;
            leds_q     <= '0;
            ocupado_q  <= 1'b0;
            invalido_q <= 1'b0;
            fim_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            codigo_q   <= codigo_d;
            leds_q     <= leds_d;
            ocupado_q  <= ocupado_d;
            invalido_q <= invalido_d;
            fim_q      <= fim_d;
        end
    end

    assign leds     = leds_q;
    assign ocupado  = ocupado_q;
    assign invalido = invalido_q;
    assign fim      = fim_q;

endmodule
`default_nettype wire
